// File: rtl/mp_accum_pkg.sv
// Shared types and constants for the multi-precision product accumulator.
package mp_accum_pkg;

    localparam int WW_DEF     = 8;
    localparam int NWORDS_DEF = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r = r + 1;
        return r;
    endfunction

endpackage

// File: rtl/mp_idx_counter.sv
// Nested i/j word-index counter: j is the inner index, i advances when j wraps.
module mp_idx_counter #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          inc,
    output logic [IW-1:0] i,
    output logic [IW-1:0] j,
    output logic          last
);

    localparam logic [IW-1:0] MAX_IDX = IW'(N - 1);

    logic [IW-1:0] i_reg, i_next;
    logic [IW-1:0] j_reg, j_next;

    always_comb begin
        i_next = i_reg;
        j_next = j_reg;
        if (clr) begin
            i_next = '0;
            j_next = '0;
        end else if (inc) begin
            if (j_reg == MAX_IDX) begin
                j_next = '0;
                i_next = (i_reg == MAX_IDX) ? '0 : i_reg + 1'b1;
            end else begin
                j_next = j_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i_reg <= '0;
            j_reg <= '0;
        end else begin
            i_reg <= i_next;
            j_reg <= j_next;
        end
    end

    assign i    = i_reg;
    assign j    = j_reg;
    assign last = (i_reg == MAX_IDX) && (j_reg == MAX_IDX);

endmodule

// File: rtl/mp_prod_accum.sv
// Column-shifting accumulator for NWORDS^2 partial products of A*B.
// Define MP_ACCUM_MAC_EN to preload from acc_init and expose a sticky carry-out (ovf).
module mp_prod_accum
    import mp_accum_pkg::*;
#(
    parameter int WW     = WW_DEF,
    parameter int NWORDS = NWORDS_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    output logic                   busy,
    input  logic [2*WW-1:0]        prod,
    input  logic                   prod_valid,
    output logic                   prod_ready,
    output logic [2*NWORDS*WW-1:0] res,
    output logic                   res_valid,
    input  logic                   res_ready
`ifdef MP_ACCUM_MAC_EN
    ,
    input  logic [2*NWORDS*WW-1:0] acc_init,
    output logic                   ovf
`endif
);

    localparam int RW   = 2 * NWORDS * WW;
    localparam int IW   = clog2(NWORDS);
    localparam int CW   = IW + 1;
    localparam int NCOL = 2 * NWORDS - 1;

    state_t          state_reg, state_next;
    logic [RW-1:0]   res_reg;
    logic [IW-1:0]   idx_i, idx_j;
    logic            idx_last;
    logic            idx_clr, idx_inc;
    logic            start_take, accept;
    logic [CW-1:0]   col;
    logic [RW-1:0]   col_shift [NCOL];
    logic [RW-1:0]   addend;
    logic [RW:0]     sum;
    logic [RW-1:0]   res_init;

    mp_idx_counter #(
        .N  (NWORDS),
        .IW (IW)
    ) u_idx (
        .clk  (clk),
        .rst  (rst),
        .clr  (idx_clr),
        .inc  (idx_inc),
        .i    (idx_i),
        .j    (idx_j),
        .last (idx_last)
    );

    // One pre-shifted copy of the product per result column i+j.
    generate
        for (genvar gi = 0; gi < NCOL; gi++) begin : g_col
            assign col_shift[gi] = {{(RW - 2*WW){1'b0}}, prod} << (WW * gi);
        end
    endgenerate

    assign col    = {1'b0, idx_i} + {1'b0, idx_j};
    assign addend = col_shift[col];
    assign sum    = {1'b0, res_reg} + {1'b0, addend};

    always_comb begin
        state_next = state_reg;
        idx_clr    = 1'b0;
        idx_inc    = 1'b0;
        start_take = 1'b0;
        accept     = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    start_take = 1'b1;
                    idx_clr    = 1'b1;
                    state_next = S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (prod_valid) begin
                    accept  = 1'b1;
                    idx_inc = 1'b1;
                    if (idx_last) state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (res_ready) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_reg <= S_IDLE;
        else     state_reg <= state_next;
    end

`ifdef MP_ACCUM_MAC_EN
    assign res_init = acc_init;

    logic ovf_reg;

    // Sticky across the whole job so a single wrap anywhere is reported.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)             ovf_reg <= 1'b0;
        else if (start_take) ovf_reg <= 1'b0;
        else if (accept)     ovf_reg <= ovf_reg | sum[RW];
    end

    assign ovf = ovf_reg;
`else
    assign res_init = '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst)             res_reg <= '0;
        else if (start_take) res_reg <= res_init;
        else if (accept)     res_reg <= sum[RW-1:0];
    end

    assign res        = res_reg;
    assign busy       = (state_reg != S_IDLE);
    assign prod_ready = (state_reg == S_ACCUM);
    assign res_valid  = (state_reg == S_DONE);

endmodule

// File: tb/tb_mp_prod_accum.sv
// Directed bench for mp_prod_accum (WW=8, NWORDS=4) with an arithmetic reference model.
module tb_mp_prod_accum;

    localparam int WW = 8;
    localparam int N  = 4;
    localparam int RW = 2 * N * WW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          busy;
    logic [15:0]   prod = '0;
    logic          prod_valid = 1'b0;
    logic          prod_ready;
    logic [RW-1:0] res;
    logic          res_valid;
    logic          res_ready = 1'b0;
`ifdef MP_ACCUM_MAC_EN
    logic [RW-1:0] acc_init = '0;
    logic          ovf;
`endif

    int vectors = 0;
    int miscompares = 0;
    int jobs = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    mp_prod_accum #(.WW(WW), .NWORDS(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .busy       (busy),
        .prod       (prod),
        .prod_valid (prod_valid),
        .prod_ready (prod_ready),
        .res        (res),
        .res_valid  (res_valid),
        .res_ready  (res_ready)
`ifdef MP_ACCUM_MAC_EN
        ,
        .acc_init   (acc_init),
        .ovf        (ovf)
`endif
    );

    // Reference model: phase 0=idle, 1=accumulating, 2=result held; m_k counts accepted products.
    int            m_phase = 0;
    int            m_k = 0;
    logic [RW-1:0] m_res = '0;
    logic          m_ovf = 1'b0;

    function automatic logic [RW:0] col_add(input logic [RW-1:0] acc, input logic [15:0] p, input int k);
        logic [RW:0] t;
        t = (RW+1)'(p) << (WW * (k / N + k % N));
        return {1'b0, acc} + t;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase <= 0;
            m_k     <= 0;
            m_res   <= '0;
            m_ovf   <= 1'b0;
        end else begin
            case (m_phase)
                0: if (start) begin
                    m_phase <= 1;
                    m_k     <= 0;
`ifdef MP_ACCUM_MAC_EN
                    m_res   <= acc_init;
`else
                    m_res   <= '0;
`endif
                    m_ovf   <= 1'b0;
                end
                1: if (prod_valid) begin
                    m_res <= col_add(m_res, prod, m_k)[RW-1:0];
                    m_ovf <= m_ovf | col_add(m_res, prod, m_k)[RW];
                    m_k   <= m_k + 1;
                    if (m_k == N * N - 1) m_phase <= 2;
                end
                2: if (res_ready) m_phase <= 0;
                default: m_phase <= 0;
            endcase
        end
    end

    task automatic check(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            check("res_vs_model", res, m_res);
            check("flags_vs_model", RW'({busy, prod_ready, res_valid}),
                  RW'({m_phase != 0, m_phase == 1, m_phase == 2}));
`ifdef MP_ACCUM_MAC_EN
            check("ovf_vs_model", RW'(ovf), RW'(m_ovf));
`endif
        end
    end

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send(input logic [15:0] p);
        prod       = p;
        prod_valid = 1'b1;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (prod_ready) begin
                @(posedge clk); #1;
                return;
            end
            @(posedge clk); #1;
        end
        vectors++;
        miscompares++;
        $display("FAIL send_timeout: prod_ready stayed %b, required 1", prod_ready);
    endtask

    task automatic finish_job(input int hold, input bit start_on_release);
        logic [RW-1:0] held;
        prod_valid = 1'b0;
        for (int t = 0; t < 50 && !res_valid; t++) begin
            @(posedge clk); #1;
        end
        check("res_valid_wait", RW'(res_valid), RW'(1));
        held = res;
        repeat (hold) begin
            @(posedge clk); #1;
        end
        check("res_held", res, held);
        check("res_valid_held", RW'(res_valid), RW'(1));
        jobs++;
        $display("job %0d: res=%h", jobs, res);
        res_ready = 1'b1;
        start     = start_on_release;
        @(posedge clk); #1;
        res_ready = 1'b0;
        start     = 1'b0;
        check("idle_after_release", RW'(busy), RW'(0));
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst    = 1'b0;
        cmp_en = 1'b1;
        check("reset_res", res, '0);
        check("reset_flags", RW'({busy, prod_ready, res_valid}), RW'(0));

        // Full scale: A=B=0xFFFFFFFF
        do_start();
        for (int k = 0; k < N * N; k++) send(16'hFE01);
        prod_valid = 1'b0;
        check("fullscale_valid_next_cycle", RW'(res_valid), RW'(1));
        check("fullscale_res", res, 64'hFFFFFFFE00000001);
        check("fullscale_model", m_res, 64'hFFFFFFFE00000001);
        finish_job(0, 1'b0);

        // Column placement of the final product
        do_start();
        for (int k = 0; k < N * N; k++) send((k == N * N - 1) ? 16'h0001 : 16'h0000);
        prod_valid = 1'b0;
        check("column_res", res, 64'h0001_0000_0000_0000);
        finish_job(0, 1'b0);

        // Gaps on prod_valid and a held result
        do_start();
        for (int k = 0; k < N * N; k++) begin
            send(16'(k * 16'h1111 + 3));
            prod_valid = 1'b0;
            @(posedge clk); #1;
        end
        finish_job(5, 1'b0);

        // start ignored mid-job and in the DONE->IDLE cycle
        do_start();
        for (int k = 0; k < N * N; k++) begin
            start = (k == 6);
            send(16'hFE01);
            start = 1'b0;
        end
        prod_valid = 1'b0;
        check("ignored_start_res", res, 64'hFFFFFFFE00000001);
        finish_job(0, 1'b1);
        @(posedge clk); #1;
        check("stays_idle", RW'({busy, prod_ready}), RW'(0));

        // Reset in the middle of a job
        do_start();
        for (int k = 0; k < 8; k++) send(16'hFE01);
        prod_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("midreset_res", res, '0);
        check("midreset_flags", RW'({prod_ready, res_valid}), RW'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        do_start();
        for (int k = 0; k < N * N; k++) send(16'hFE01);
        prod_valid = 1'b0;
        check("after_reset_res", res, 64'hFFFFFFFE00000001);
        finish_job(0, 1'b0);

`ifdef MP_ACCUM_MAC_EN
        acc_init = '1;
        do_start();
        for (int k = 0; k < N * N; k++) send((k == 0) ? 16'h0001 : 16'h0000);
        prod_valid = 1'b0;
        check("mac_res", res, '0);
        check("mac_ovf", RW'(ovf), RW'(1));
        finish_job(0, 1'b0);
        acc_init = '0;
        do_start();
        check("mac_ovf_cleared", RW'(ovf), RW'(0));
        for (int k = 0; k < N * N; k++) send(16'h0000);
        finish_job(0, 1'b0);
`endif

        @(posedge clk); #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
